id_scroll_display: RTL and testbench
====================================

# id_scroll_display

Downstream display stage for the ID digit sequencer. Each time the 1 s timer advances the position counter, the block captures the current ID numeral into a six-digit shift buffer and drives six active-low seven-segment displays. The ID therefore scrolls right-to-left across HEX5..HEX0. At the ID wrap point it optionally inserts a blank separator digit.

## Interface
- NUM_POSITIONS, 8: number of ID positions; wrap is detected when Position == 0.
- clk  input  1  system clock (CLOCK_50); all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  one-cycle advance strobe, the same pulse that increments the position counter.
- Numeral  input  4  ID digit for the current Position (0–9 valid).
- Position  input  3  current position counter value.
- Hold  input  1  freeze display; strobes are ignored while high.
- HEX0..HEX5  output  7 each  active-low segments; bit0 = a … bit6 = g; HEX0 = newest digit.
- Full  output  1  high once six digit slots have been loaded since reset.

## Operation
- Buffer: six 5-bit slots, each holding {blank, value[3:0]}. Segment decode is combinational from the buffer.
- Decode table (a..g, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
  - values 10–15 = dash 0111111 (error indication)
- A capture happens on a cycle with Enable=1, Hold=0 and Reset=0. Numeral and Position are sampled on that cycle, before the counter increments.
- Normal capture: shift toward HEX5 (HEX5←HEX4 … HEX1←HEX0), then HEX0←Numeral; the old HEX5 digit is discarded.
- Gap capture (SCROLL_GAP_EN only): applies when Position == 0 and state ≠ EMPTY. Shift two slots in one cycle: HEX1←blank, HEX0←Numeral.
- State machine:
  - EMPTY: reset state, all slots blank. First capture goes to FILL and is never a gap capture.
  - FILL: loaded-count 1–5. Moves to SCROLL when the count reaches 6.
  - SCROLL: Full=1; captures continue to shift.
- Loaded-count is 3 bits and saturates at 6. A gap capture adds 2; a normal capture adds 1.
- Hold does not alter the buffer or state. Strobes arriving during Hold are dropped, not queued.

## Timing
- Reset values: all HEX outputs 1111111, Full=0, state EMPTY, count 0.
- Latency: a capture on cycle N is visible on HEX and Full from cycle N+1.
- Reset mid-operation: buffer cleared on the next edge. The next capture is treated as first, so no gap is inserted even when Position == 0.
- Reset and Enable in the same cycle: reset wins; the digit is lost.
- Hold and Enable in the same cycle: Hold wins.
- Back-to-back strobes on consecutive cycles: each is captured. The block does not assume 1 s spacing.
- Count passing through 5 via a gap capture saturates at 6 and enters SCROLL on the same edge.

## Configuration
- SCROLL_GAP_EN defined: a blank separator slot is inserted before the Position-0 numeral on every wrap after the first pass.
- SCROLL_GAP_EN undefined: every capture is a single-slot shift, giving a continuous scroll with no separator.

## Test plan
- Reset sequence: Reset high 2 cycles, then low → HEX0..HEX5 = 1111111, Full=0.
- Fill: six strobes with Position 0..5 and Numeral = Position+1 → HEX5..HEX0 = 1,2,3,4,5,6. Full rises the cycle after the sixth strobe.
- Wrap, continuing to Position 7 (Numeral 8), then Position 0 with Numeral 1:
  - with SCROLL_GAP_EN → HEX5..HEX0 = 5,6,7,8,blank,1
  - without SCROLL_GAP_EN → 4,5,6,7,8,1
- Hold: Hold=1 with three strobes → outputs unchanged. Release Hold, one strobe → only one new digit shifted in.
- Invalid digit: Numeral=12 captured → HEX0 = 0111111 (dash).
- Reset mid-scroll: Reset pulsed, then strobe at Position 0 with Numeral 1 → HEX0 = 1111001, HEX1..HEX5 blank, no gap, Full=0.

Source files
------------

// File: rtl/id_scroll_display.sv
// Six-digit right-to-left scrolling ID display with active-low seven-segment outputs.
// Define SCROLL_GAP_EN to insert a blank separator slot ahead of each wrapped Position-0 digit.
module id_scroll_display #(
   parameter int unsigned NUM_POSITIONS = 8,
   localparam int unsigned PosW = $clog2(NUM_POSITIONS)
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            Enable,
   input  logic [3:0]      Numeral,
   input  logic [PosW-1:0] Position,
   input  logic            Hold,
   output logic [6:0]      HEX0,
   output logic [6:0]      HEX1,
   output logic [6:0]      HEX2,
   output logic [6:0]      HEX3,
   output logic [6:0]      HEX4,
   output logic [6:0]      HEX5,
   output logic            Full
);

`ifdef SCROLL_GAP_EN
   localparam bit GapEn = 1'b1;
`else
   localparam bit GapEn = 1'b0;
`endif

   localparam logic [4:0] BlankSlot = 5'b1_0000;

   typedef enum logic [1:0] {StEmpty, StFill, StScroll} state_e;

   state_e     state_q, state_d;
   logic [2:0] count_q, count_d;
   // Slot 0 drives HEX0 (newest digit); each slot is {blank, value}.
   logic [4:0] slot_q [6];
   logic [4:0] slot_d [6];
   logic       capture;
   logic       gap;

   always_comb begin
      capture = Enable && !Hold;
      gap     = GapEn && capture && (Position == '0) && (state_q != StEmpty);
      state_d = state_q;
      count_d = count_q;
      for (int i = 0; i < 6; i++) slot_d[i] = slot_q[i];

      if (capture) begin
         if (gap) begin
            for (int i = 2; i < 6; i++) slot_d[i] = slot_q[i-2];
            slot_d[1] = BlankSlot;
            slot_d[0] = {1'b0, Numeral};
            count_d   = (count_q >= 3'd4) ? 3'd6 : count_q + 3'd2;
         end else begin
            for (int i = 1; i < 6; i++) slot_d[i] = slot_q[i-1];
            slot_d[0] = {1'b0, Numeral};
            count_d   = (count_q >= 3'd5) ? 3'd6 : count_q + 3'd1;
         end

         unique case (state_q)
            StEmpty: state_d = StFill;
            StFill:  if (count_d == 3'd6) state_d = StScroll;
            default: state_d = StScroll;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= StEmpty;
         count_q <= 3'd0;
         for (int i = 0; i < 6; i++) slot_q[i] <= BlankSlot;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         for (int i = 0; i < 6; i++) slot_q[i] <= slot_d[i];
      end
   end

   function automatic logic [6:0] seg_decode(input logic [4:0] s);
      logic [6:0] seg;
      if (s[4]) begin
         seg = 7'b1111111;
      end else begin
         case (s[3:0])
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;  // dash marks a non-decimal numeral
         endcase
      end
      return seg;
   endfunction

   assign HEX0 = seg_decode(slot_q[0]);
   assign HEX1 = seg_decode(slot_q[1]);
   assign HEX2 = seg_decode(slot_q[2]);
   assign HEX3 = seg_decode(slot_q[3]);
   assign HEX4 = seg_decode(slot_q[4]);
   assign HEX5 = seg_decode(slot_q[5]);
   assign Full = (state_q == StScroll);

endmodule

// File: tb/tb_id_scroll_display.sv
// Table-driven directed vectors plus randomized traffic checked against a digit-queue model.
module tb_id_scroll_display;

`ifdef SCROLL_GAP_EN
   localparam bit GapEn = 1'b1;
`else
   localparam bit GapEn = 1'b0;
`endif

   localparam int B = 16;  // blank digit code
   localparam logic [6:0] SegTab [17] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
      7'b1111111
   };

   logic       clk = 1'b0;
   logic       Reset, Enable, Hold;
   logic [3:0] Numeral;
   logic [2:0] Position;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic       Full;

   always #5 clk = ~clk;

   id_scroll_display #(.NUM_POSITIONS(8)) dut (
      .clk      (clk),
      .Reset    (Reset),
      .Enable   (Enable),
      .Numeral  (Numeral),
      .Position (Position),
      .Hold     (Hold),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5),
      .Full     (Full)
   );

   typedef struct {
      logic            rst;
      logic            en;
      logic            hold;
      logic [3:0]      num;
      logic [2:0]      pos;
      logic [5:0][4:0] dig;   // dig[5] = HEX5 ... dig[0] = HEX0
      logic            full;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   mq[$];     // displayed digits, oldest first, newest at back
   int   loaded;

   task automatic add(input logic rst, input logic en, input logic hold, input int num,
                      input int pos, input int d5, input int d4, input int d3, input int d2,
                      input int d1, input int d0, input logic full);
      vec_t v;
      v.rst  = rst;
      v.en   = en;
      v.hold = hold;
      v.num  = 4'(num);
      v.pos  = 3'(pos);
      v.dig  = {5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
      v.full = full;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic en, input logic hold,
                        input logic [3:0] num, input logic [2:0] pos);
      Reset    = rst;
      Enable   = en;
      Hold     = hold;
      Numeral  = num;
      Position = pos;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [5:0][4:0] dig, input logic full);
      logic [48:0] act;
      logic [48:0] exp;
      act = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, Full};
      exp = {SegTab[dig[5]], SegTab[dig[4]], SegTab[dig[3]], SegTab[dig[2]],
             SegTab[dig[1]], SegTab[dig[0]], full};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got HEX5..0,Full=%h want %h", name, act, exp);
      end
   endtask

   task automatic mdl_reset();
      mq = {};
      repeat (6) mq.push_back(B);
      loaded = 0;
   endtask

   task automatic mdl_capture(input int num, input int pos);
      if (GapEn && pos == 0 && loaded > 0) begin
         mq.push_back(B);
         loaded++;
      end
      mq.push_back(num);
      loaded++;
      if (loaded > 6) loaded = 6;
      while (mq.size() > 6) void'(mq.pop_front());
   endtask

   initial begin
      logic [5:0][4:0] dig;
      logic rst, en, hold;
      logic [3:0] num;
      logic [2:0] pos;

      Reset = 1'b1; Enable = 1'b0; Hold = 1'b0; Numeral = '0; Position = '0;

      add(1, 0, 0, 0, 0, B, B, B, B, B, B, 0);
      add(1, 0, 0, 0, 0, B, B, B, B, B, B, 0);
      add(0, 0, 0, 0, 0, B, B, B, B, B, B, 0);
      add(0, 1, 0, 1, 0, B, B, B, B, B, 1, 0);
      add(0, 1, 0, 2, 1, B, B, B, B, 1, 2, 0);
      add(0, 1, 0, 3, 2, B, B, B, 1, 2, 3, 0);
      add(0, 1, 0, 4, 3, B, B, 1, 2, 3, 4, 0);
      add(0, 1, 0, 5, 4, B, 1, 2, 3, 4, 5, 0);
      add(0, 1, 0, 6, 5, 1, 2, 3, 4, 5, 6, 1);
      add(0, 1, 0, 7, 6, 2, 3, 4, 5, 6, 7, 1);
      add(0, 1, 0, 8, 7, 3, 4, 5, 6, 7, 8, 1);
`ifdef SCROLL_GAP_EN
      add(0, 1, 0, 1, 0, 5, 6, 7, 8, B, 1, 1);
      repeat (3) add(0, 1, 1, 9, 1, 5, 6, 7, 8, B, 1, 1);
      add(0, 1, 0, 2, 1, 6, 7, 8, B, 1, 2, 1);
      add(0, 1, 0, 12, 2, 7, 8, B, 1, 2, 12, 1);
`else
      add(0, 1, 0, 1, 0, 4, 5, 6, 7, 8, 1, 1);
      repeat (3) add(0, 1, 1, 9, 1, 4, 5, 6, 7, 8, 1, 1);
      add(0, 1, 0, 2, 1, 5, 6, 7, 8, 1, 2, 1);
      add(0, 1, 0, 12, 2, 6, 7, 8, 1, 2, 12, 1);
`endif
      add(1, 1, 0, 4, 3, B, B, B, B, B, B, 0);
      add(0, 1, 0, 1, 0, B, B, B, B, B, 1, 0);
      // Gap capture with count at 5 must saturate and assert Full on the same edge
      add(1, 0, 0, 0, 0, B, B, B, B, B, B, 0);
      add(0, 1, 0, 1, 1, B, B, B, B, B, 1, 0);
      add(0, 1, 0, 2, 2, B, B, B, B, 1, 2, 0);
      add(0, 1, 0, 3, 3, B, B, B, 1, 2, 3, 0);
      add(0, 1, 0, 4, 4, B, B, 1, 2, 3, 4, 0);
      add(0, 1, 0, 5, 5, B, 1, 2, 3, 4, 5, 0);
`ifdef SCROLL_GAP_EN
      add(0, 1, 0, 0, 0, 2, 3, 4, 5, B, 0, 1);
`else
      add(0, 1, 0, 0, 0, 1, 2, 3, 4, 5, 0, 1);
`endif

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].hold, vecs[i].num, vecs[i].pos);
         check($sformatf("vec%0d", i), vecs[i].dig, vecs[i].full);
      end

      mdl_reset();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
      for (int n = 0; n < 600; n++) begin
         rst  = ($urandom_range(0, 39) == 0);
         en   = ($urandom_range(0, 1) == 1);
         hold = ($urandom_range(0, 4) == 0);
         num  = 4'($urandom_range(0, 15));
         pos  = 3'($urandom_range(0, 7));
         if (rst) mdl_reset();
         else if (en && !hold) mdl_capture(int'(num), int'(pos));
         drive(rst, en, hold, num, pos);
         for (int k = 0; k < 6; k++) dig[k] = 5'(mq[5-k]);
         check($sformatf("rand%0d", n), dig, loaded == 6);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
